// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
// Holds the sequencer state enum, default init/idle words and index-width helper.
package instr_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;
  localparam int unsigned CNT_W         = 16;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A read and write to the same word on the same edge returns the old contents.
module imem_ram_1r1w
  import instr_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IDX_W = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Both ports use non-blocking updates, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory for the fetch stage: registered byte-addressed
// fetch with stall hold and fault flag, loader port, and post-reset init sequencer.
module instr_mem_sync
  import instr_mem_pkg::*;
#(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          DEPTH     = 256,
  parameter int unsigned          ADDR_W    = 10,
  parameter logic [DATA_W-1:0]    HALT_WORD = DATA_W'(DEF_HALT_WORD),
  parameter logic [DATA_W-1:0]    NOP_WORD  = DATA_W'(DEF_NOP_WORD),
  localparam int unsigned         IDX_W     = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              init_busy,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int unsigned     FIDX_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_init_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;

  logic               r_valid;
  logic               r_fault;
  logic [CNT_W-1:0]   r_count;

  logic               w_ram_we;
  logic [IDX_W-1:0]   w_ram_waddr;
  logic [DATA_W-1:0]  w_ram_wdata;
  logic               w_ram_re;
  logic [DATA_W-1:0]  w_ram_rdata;

  logic               w_accept;
  logic               w_fault;
  logic               w_oor;
  logic [FIDX_W-1:0]  w_fidx;

  assign w_fidx = fetch_addr[ADDR_W-1:2];

  // Any set bit above the array index range means the word is out of range.
  generate
    if (FIDX_W > IDX_W) begin : g_hi
      assign w_oor = |w_fidx[FIDX_W-1:IDX_W];
    end else begin : g_nohi
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_fault = (fetch_addr[1:0] != 2'b00) || w_oor;

  // State register and init pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_ptr_nxt;
    end
  end

  // Next-state, init writer and write-port mux (init has the port during INIT).
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_init_ptr;
    w_ram_we    = 1'b0;
    w_ram_waddr = load_addr;
    w_ram_wdata = load_data;
    w_accept    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_init_ptr;
        w_ram_wdata = (r_init_ptr == '0) ? HALT_WORD : '0;
        if (r_init_ptr == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_ptr_nxt = r_init_ptr + IDX_W'(1);
        end
      end
      ST_RUN: begin
        w_ram_we = load_en;
        w_accept = fetch_req && !stall;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
    if (reset) begin
      w_ram_we = 1'b0;
      w_accept = 1'b0;
    end
  end

  // Faulted fetches never touch the array; a disabled read holds the last word.
  assign w_ram_re = w_accept && !w_fault;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_fidx[IDX_W-1:0]),
    .o_rdata (w_ram_rdata)
  );

  // Fetch result flags and saturating accepted-fetch counter; stall freezes all.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_count <= '0;
    end else if (r_state == ST_INIT) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (!stall) begin
      r_valid <= w_accept;
      r_fault <= w_accept && w_fault;
      if (w_accept && (r_count != CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;
  assign instruction = (r_valid && !r_fault) ? w_ram_rdata : NOP_WORD;
  assign init_busy   = (r_state == ST_INIT);
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync (DEPTH=256, ADDR_W=11): init timing, fetch,
// load, faults, stall hold, read-before-write, counter saturation, mid-init reset.
module tb_instr_mem_sync;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned IDX_W  = 8;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              instr_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_fault;
  logic              load_en;
  logic [IDX_W-1:0]  load_addr;
  logic [DATA_W-1:0] load_data;
  logic              init_busy;
  logic [15:0]       fetch_count;

  int n_checks;
  int n_fail;

  instr_mem_sync #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .fetch_fault (fetch_fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .init_busy   (init_busy),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              stl;
    logic              ld;
    logic [IDX_W-1:0]  laddr;
    logic [DATA_W-1:0] ldata;
    logic              ev;
    logic [DATA_W-1:0] ei;
    logic              ef;
    logic [15:0]       ec;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    stall      = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
  endtask

  // Counts cycles with init_busy high; must already be just after an edge.
  task automatic measure_init(input string name);
    int cycles;
    int bad_valid;
    cycles    = 0;
    bad_valid = 0;
    while (init_busy && cycles < 1000) begin
      cycles++;
      if (instr_valid !== 1'b0) bad_valid++;
      tick();
    end
    idle_inputs();
    chk({name, "_busy_cycles"}, 32'(cycles), 32'd256);
    chk({name, "_valid_during_init"}, 32'(bad_valid), 32'd0);
  endtask

  function automatic vec_t mk(input logic req, input logic [ADDR_W-1:0] addr,
                              input logic stl, input logic ld, input logic [IDX_W-1:0] laddr,
                              input logic [DATA_W-1:0] ldata, input logic ev,
                              input logic [DATA_W-1:0] ei, input logic ef, input logic [15:0] ec);
    vec_t v;
    v.req = req; v.addr = addr; v.stl = stl; v.ld = ld; v.laddr = laddr; v.ldata = ldata;
    v.ev = ev; v.ei = ei; v.ef = ef; v.ec = ec;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //           req addr    stl ld laddr ldata          ev ei             ef ec
    vecs[0]  = mk(1, 11'h000, 0, 0, 8'd0, 32'h0,          1, 32'hFFFFFFFF, 0, 16'd1);
    vecs[1]  = mk(1, 11'h004, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 0, 16'd2);
    vecs[2]  = mk(0, 11'h000, 0, 0, 8'd0, 32'h0,          0, 32'h00000000, 0, 16'd2);
    vecs[3]  = mk(0, 11'h000, 0, 1, 8'd3, 32'h2008_0005,  0, 32'h00000000, 0, 16'd2);
    vecs[4]  = mk(1, 11'h00C, 0, 0, 8'd0, 32'h0,          1, 32'h20080005, 0, 16'd3);
    vecs[5]  = mk(1, 11'h006, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 1, 16'd4);
    vecs[6]  = mk(1, 11'h400, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 1, 16'd5);
    vecs[7]  = mk(1, 11'h7FC, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 1, 16'd6);
    vecs[8]  = mk(1, 11'h01C, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 0, 16'd7);
    vecs[9]  = mk(1, 11'h00C, 0, 0, 8'd0, 32'h0,          1, 32'h20080005, 0, 16'd8);
    vecs[10] = mk(1, 11'h000, 1, 0, 8'd0, 32'h0,          1, 32'h20080005, 0, 16'd8);
    vecs[11] = mk(1, 11'h004, 1, 0, 8'd0, 32'h0,          1, 32'h20080005, 0, 16'd8);
    vecs[12] = mk(1, 11'h006, 1, 1, 8'd6, 32'h1234_5678,  1, 32'h20080005, 0, 16'd8);
    vecs[13] = mk(1, 11'h014, 0, 1, 8'd5, 32'hAAAA_AAAA,  1, 32'h00000000, 0, 16'd9);
    vecs[14] = mk(1, 11'h014, 0, 0, 8'd0, 32'h0,          1, 32'hAAAAAAAA, 0, 16'd10);
    vecs[15] = mk(1, 11'h018, 0, 0, 8'd0, 32'h0,          1, 32'h12345678, 0, 16'd11);
    vecs[16] = mk(1, 11'h001, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 1, 16'd12);
    vecs[17] = mk(1, 11'h000, 1, 0, 8'd0, 32'h0,          1, 32'h00000000, 1, 16'd12);
    vecs[18] = mk(0, 11'h000, 0, 0, 8'd0, 32'h0,          0, 32'h00000000, 0, 16'd12);
    vecs[19] = mk(1, 11'h000, 1, 0, 8'd0, 32'h0,          0, 32'h00000000, 0, 16'd12);
    vecs[20] = mk(1, 11'h3FC, 0, 0, 8'd0, 32'h0,          1, 32'h00000000, 0, 16'd13);

    // Reset values.
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);

    // Init with fetches and a load to word 7 attempted; all must be ignored.
    reset      = 1'b0;
    fetch_req  = 1'b1;
    load_en    = 1'b1;
    load_addr  = 8'd7;
    load_data  = 32'hDEAD_BEEF;
    measure_init("init1");
    chk("init1_count", 32'(fetch_count), 32'd0);

    // Table-driven run-mode vectors.
    for (int i = 0; i < NVEC; i++) begin
      fetch_req  = vecs[i].req;
      fetch_addr = vecs[i].addr;
      stall      = vecs[i].stl;
      load_en    = vecs[i].ld;
      load_addr  = vecs[i].laddr;
      load_data  = vecs[i].ldata;
      tick();
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d_instr", i), instruction, vecs[i].ei);
      chk($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].ef));
      chk($sformatf("v%0d_count", i), 32'(fetch_count), 32'(vecs[i].ec));
    end
    idle_inputs();

    // Counter saturation: drive up to 0xFFFE, then two more fetches.
    fetch_req  = 1'b1;
    fetch_addr = 11'h000;
    for (int i = 0; i < 65534 - 13; i++) tick();
    chk("sat_fffe", 32'(fetch_count), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(fetch_count), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(fetch_count), 32'h0000_FFFF);
    chk("sat_instr", instruction, 32'hFFFF_FFFF);
    idle_inputs();

    // Reset from RUN, then a one-cycle reset 100 cycles into INIT.
    reset = 1'b1;
    tick();
    chk("rst2_count", 32'(fetch_count), 32'd0);
    chk("rst2_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_init_busy", 32'(init_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    measure_init("init2");

    fetch_req  = 1'b1;
    fetch_addr = 11'h00C;
    tick();
    chk("post_w3_instr", instruction, 32'h0);
    chk("post_w3_valid", 32'(instr_valid), 32'd1);
    fetch_addr = 11'h000;
    tick();
    chk("post_w0_instr", instruction, 32'hFFFF_FFFF);
    chk("post_count", 32'(fetch_count), 32'd2);
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
